seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_slot_timer.sv | 79 +++++++
 rtl/seg7_scan_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width,
// blank patterns for both segment polarities, and the full-brightness code.
package seg7_pkg;

  localparam int         SEG_W        = 7;
  localparam logic [6:0] SEG_BLANK_AL = 7'h7F;
  localparam logic [6:0] SEG_BLANK_AH = 7'h00;
  localparam logic [3:0] BRIGHT_FULL  = 4'hF;

  // Blank segment level for the chosen segment polarity.
  function automatic logic [SEG_W-1:0] seg_blank(input logic active_low);
    return active_low ? SEG_BLANK_AL : SEG_BLANK_AH;
  endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Scan timing for the seven-segment driver: per-digit slot counter, digit
// index, frame counter and blink phase. Also flags the snapshot edge and
// whether the current slot is past its anode dead time.
module seg7_slot_timer #(
  parameter int NUM_DIGITS   = 6,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          live,
  output logic                          blink_phase,
  output logic                          snap_stb
);

  localparam int SLOT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0]  slot_reg, slot_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic               blink_reg, blink_next;

  logic slot_wrap;
  logic idx_wrap;
  logic frame_wrap;

  assign slot_wrap  = (slot_reg == SLOT_W'(REFRESH_DIV - 1));
  assign idx_wrap   = (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = (frame_reg == FRAME_W'(BLINK_FRAMES - 1));

  // Next-state: slot counter rolls into the digit index, the index wrap
  // closes a frame, and every BLINK_FRAMES closed frames flip the blink phase.
  always_comb begin
    slot_next  = slot_reg + SLOT_W'(1);
    idx_next   = idx_reg;
    frame_next = frame_reg;
    blink_next = blink_reg;
    if (slot_wrap) begin
      slot_next = '0;
      if (idx_wrap) begin
        idx_next = '0;
        if (frame_wrap) begin
          frame_next = '0;
          blink_next = ~blink_reg;
        end else begin
          frame_next = frame_reg + FRAME_W'(1);
        end
      end else begin
        idx_next = idx_reg + IDX_W'(1);
      end
    end
  end

  // State registers, all cleared so the scan restarts at digit 0, slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg  <= '0;
      idx_reg   <= '0;
      frame_reg <= '0;
      blink_reg <= 1'b0;
    end else begin
      slot_reg  <= slot_next;
      idx_reg   <= idx_next;
      frame_reg <= frame_next;
      blink_reg <= blink_next;
    end
  end

  // The snapshot edge is slot 0 of digit 0, which always sits in dead time.
  assign snap_stb    = (slot_reg == '0) && (idx_reg == '0);
  assign live        = (slot_reg >= SLOT_W'(DEAD_CYCLES));
  assign idx         = idx_reg;
  assign blink_phase = blink_reg;

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. Captures all digit patterns once
// per frame, scans them onto a shared segment bus with one-hot anodes,
// and applies dead time, per-digit blink and global PWM brightness.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter int BLINK_FRAMES   = 32,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEG_W*NUM_DIGITS-1:0]   seg_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic [3:0]                    brightness,
  output logic [SEG_W-1:0]              seg_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          frame_start
);

  localparam int                    IDX_W  = $clog2(NUM_DIGITS);
  localparam logic [SEG_W-1:0]      BLANK  = seg_blank(SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ?
                                             {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [IDX_W-1:0] idx;
  logic             live;
  logic             blink_phase;
  logic             snap_stb;

  seg7_slot_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .DEAD_CYCLES  (DEAD_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .idx         (idx),
    .live        (live),
    .blink_phase (blink_phase),
    .snap_stb    (snap_stb)
  );

  logic [SEG_W-1:0]      seg_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] onehot;

  // Unpack the flat decoder bus and decode the scan index to one-hot.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign seg_arr[gi] = seg_in[SEG_W*gi +: SEG_W];
    assign onehot[gi]  = (idx == IDX_W'(gi));
  end

  logic [SEG_W-1:0]      snap_seg_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_en_reg;
  logic [NUM_DIGITS-1:0] snap_blink_reg;

  // Frame snapshot: inputs are sampled only at the snapshot edge so a
  // frame never mixes old and new patterns.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_seg_reg[i] <= BLANK;
      snap_en_reg    <= '0;
      snap_blink_reg <= '0;
    end else if (snap_stb) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_seg_reg[i] <= seg_arr[i];
      snap_en_reg    <= digit_en;
      snap_blink_reg <= blink_mask;
    end
  end

  logic [3:0] pwm_reg;

  // Free-running brightness PWM phase.
  always_ff @(posedge clk) begin
    if (rst) pwm_reg <= '0;
    else     pwm_reg <= pwm_reg + 4'd1;
  end

  logic                  lit;
  logic [SEG_W-1:0]      seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Light the current digit only past dead time, when enabled, not blinked
  // off, and inside the PWM on-window; otherwise blank everything.
  always_comb begin
    lit = live
          && snap_en_reg[idx]
          && !(blink_phase && snap_blink_reg[idx])
          && ((brightness == BRIGHT_FULL) || (pwm_reg < brightness));
    seg_next = BLANK;
    an_next  = AN_OFF;
    if (lit) begin
      seg_next = snap_seg_reg[idx];
      an_next  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end
  end

  // Registered pins; frame_start trails the snapshot edge by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out     <= BLANK;
      an_out      <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      seg_out     <= seg_next;
      an_out      <= an_next;
      frame_start <= snap_stb;
    end
  end

endmodule
